// File: rtl/set_assoc_cache.sv
`default_nettype none
// ============================================================================
// Module   : set_assoc_cache
// Brief    : N-way set-associative write-back/write-allocate cache with true
//            per-set LRU and a registered writeback/fill miss sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module set_assoc_cache #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int WORD_WIDTH    = 32,
  parameter int LINE_SIZE     = 128,
  parameter int NUM_SETS      = 4,
  parameter int NUM_WAYS      = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     access,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [WORD_WIDTH-1:0]    data_in,
  input  logic                     op,
  input  logic                     byte_op,
  output logic [WORD_WIDTH-1:0]    data_out,
  output logic                     data_ready,
  output logic                     busy,
  output logic                     mem_enable,
  output logic                     mem_op,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [LINE_SIZE-1:0]     mem_data_in,
  input  logic [LINE_SIZE-1:0]     mem_data_out,
  input  logic                     mem_data_ready,
  input  logic                     memory_in_use
);

  localparam int c_offset_w       = $clog2(LINE_SIZE/8);
  localparam int c_bytes_per_word = WORD_WIDTH/8;
  localparam int c_idx_bits       = $clog2(NUM_SETS);
  localparam int c_set_w          = (c_idx_bits > 0) ? c_idx_bits : 1;
  localparam int c_way_w          = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int c_tag_w          = ADDRESS_WIDTH - c_offset_w - c_idx_bits;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_FILL      = 2'd2,
    S_RESPOND   = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [c_tag_w-1:0]   r_tag   [NUM_SETS][NUM_WAYS];
  logic [LINE_SIZE-1:0] r_line  [NUM_SETS][NUM_WAYS];
  logic                 r_valid [NUM_SETS][NUM_WAYS];
  logic                 r_dirty [NUM_SETS][NUM_WAYS];
  logic [c_way_w-1:0]   r_age   [NUM_SETS][NUM_WAYS];

  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [WORD_WIDTH-1:0]    r_wdata;
  logic                     r_op, r_byte_op;
  logic [c_way_w-1:0]       r_victim;

  logic [WORD_WIDTH-1:0]    r_data_out, w_data_out_nxt;
  logic                     r_data_ready, w_data_ready_nxt;
  logic                     r_busy, w_busy_nxt;
  logic                     r_mem_enable, w_mem_enable_nxt;
  logic                     r_mem_op, w_mem_op_nxt;
  logic [ADDRESS_WIDTH-1:0] r_mem_address, w_mem_address_nxt;
  logic [LINE_SIZE-1:0]     r_mem_data_in, w_mem_data_in_nxt;

  logic [c_set_w-1:0]       w_idx, w_lat_idx;
  logic [c_tag_w-1:0]       w_tag, w_lat_tag;
  logic [ADDRESS_WIDTH-1:0] w_wb_addr, w_line_addr, w_lat_line_addr;
  logic                     w_hit, w_victim_dirty;
  logic [c_way_w-1:0]       w_hit_way, w_victim;

  logic                     w_in_idle, w_hit_evt, w_wb_done, w_fill_done, w_update;
  logic [c_set_w-1:0]       w_acc_set;
  logic [c_way_w-1:0]       w_acc_way;
  logic [LINE_SIZE-1:0]     w_src_line, w_new_line;
  logic [c_offset_w-1:0]    w_src_off;
  logic                     w_src_read, w_src_byte;
  logic [WORD_WIDTH-1:0]    w_src_wdata, w_rdata;

  function automatic logic [WORD_WIDTH-1:0] f_read(input logic [LINE_SIZE-1:0]  line,
                                                   input logic [c_offset_w-1:0] off,
                                                   input logic                  is_byte);
    int wi, bi;
    logic [WORD_WIDTH-1:0] word;
    wi   = int'(off) / c_bytes_per_word;
    bi   = int'(off) % c_bytes_per_word;
    word = line[wi*WORD_WIDTH +: WORD_WIDTH];
    if (is_byte) f_read = WORD_WIDTH'(word[bi*8 +: 8]);
    else         f_read = word;
  endfunction

  function automatic logic [LINE_SIZE-1:0] f_merge(input logic [LINE_SIZE-1:0]  line,
                                                   input logic [c_offset_w-1:0] off,
                                                   input logic                  is_byte,
                                                   input logic [WORD_WIDTH-1:0] wdata);
    int wi, bi;
    logic [LINE_SIZE-1:0] line_n;
    wi     = int'(off) / c_bytes_per_word;
    bi     = int'(off) % c_bytes_per_word;
    line_n = line;
    if (is_byte) line_n[wi*WORD_WIDTH + bi*8 +: 8] = wdata[7:0];
    else         line_n[wi*WORD_WIDTH +: WORD_WIDTH] = wdata;
    f_merge = line_n;
  endfunction

  generate
    if (c_idx_bits > 0) begin : g_idx
      assign w_idx     = address[c_offset_w +: c_idx_bits];
      assign w_lat_idx = r_addr[c_offset_w +: c_idx_bits];
    end else begin : g_no_idx
      assign w_idx     = 1'b0;
      assign w_lat_idx = 1'b0;
    end
  endgenerate

  assign w_tag           = address[ADDRESS_WIDTH-1 -: c_tag_w];
  assign w_lat_tag       = r_addr[ADDRESS_WIDTH-1 -: c_tag_w];
  assign w_line_addr     = {address[ADDRESS_WIDTH-1:c_offset_w], {c_offset_w{1'b0}}};
  assign w_lat_line_addr = {r_addr[ADDRESS_WIDTH-1:c_offset_w], {c_offset_w{1'b0}}};
  assign w_wb_addr       = (ADDRESS_WIDTH'(r_tag[w_idx][w_victim]) << (c_offset_w + c_idx_bits))
                         | (ADDRESS_WIDTH'(w_idx) << c_offset_w);

  // Victim: lowest-numbered invalid way wins over the age-0 (least recent) way.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_victim  = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = c_way_w'(w);
      end
    end
    for (int w = NUM_WAYS-1; w >= 0; w--)
      if (r_age[w_idx][w] == '0) w_victim = c_way_w'(w);
    for (int w = NUM_WAYS-1; w >= 0; w--)
      if (!r_valid[w_idx][w]) w_victim = c_way_w'(w);
  end

  assign w_victim_dirty = r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim];

  // One datapath serves both a hit in IDLE and the line arriving at fill completion.
  assign w_in_idle   = (r_state == S_IDLE);
  assign w_acc_set   = w_in_idle ? w_idx : w_lat_idx;
  assign w_acc_way   = w_in_idle ? w_hit_way : r_victim;
  assign w_src_line  = w_in_idle ? r_line[w_idx][w_hit_way] : mem_data_out;
  assign w_src_off   = w_in_idle ? address[c_offset_w-1:0] : r_addr[c_offset_w-1:0];
  assign w_src_read  = w_in_idle ? op : r_op;
  assign w_src_byte  = w_in_idle ? byte_op : r_byte_op;
  assign w_src_wdata = w_in_idle ? data_in : r_wdata;
  assign w_rdata     = f_read(w_src_line, w_src_off, w_src_byte);
  assign w_new_line  = w_src_read ? w_src_line : f_merge(w_src_line, w_src_off, w_src_byte, w_src_wdata);

  assign w_hit_evt   = w_in_idle && access && w_hit;
  assign w_wb_done   = (r_state == S_WRITEBACK) && r_mem_enable && mem_data_ready;
  assign w_fill_done = (r_state == S_FILL) && r_mem_enable && mem_data_ready;
  assign w_update    = w_hit_evt || w_fill_done;

  always_comb begin
    w_state_nxt       = r_state;
    w_busy_nxt        = r_busy;
    w_data_ready_nxt  = 1'b0;
    w_data_out_nxt    = r_data_out;
    w_mem_enable_nxt  = r_mem_enable;
    w_mem_op_nxt      = r_mem_op;
    w_mem_address_nxt = r_mem_address;
    w_mem_data_in_nxt = r_mem_data_in;
    case (r_state)
      S_IDLE: begin
        if (access) begin
          w_busy_nxt = 1'b1;
          if (w_hit) begin
            w_state_nxt      = S_RESPOND;
            w_data_ready_nxt = 1'b1;
            if (op) w_data_out_nxt = w_rdata;
          end else begin
            w_mem_enable_nxt = !memory_in_use;
            if (w_victim_dirty) begin
              w_state_nxt       = S_WRITEBACK;
              w_mem_op_nxt      = 1'b1;
              w_mem_address_nxt = w_wb_addr;
              w_mem_data_in_nxt = r_line[w_idx][w_victim];
            end else begin
              w_state_nxt       = S_FILL;
              w_mem_op_nxt      = 1'b0;
              w_mem_address_nxt = w_line_addr;
            end
          end
        end
      end
      S_WRITEBACK: begin
        if (w_wb_done) begin
          w_state_nxt       = S_FILL;
          w_mem_op_nxt      = 1'b0;
          w_mem_address_nxt = w_lat_line_addr;
          w_mem_enable_nxt  = !memory_in_use;
        end else if (!r_mem_enable && !memory_in_use) begin
          w_mem_enable_nxt = 1'b1;
        end
      end
      S_FILL: begin
        if (w_fill_done) begin
          w_state_nxt      = S_RESPOND;
          w_mem_enable_nxt = 1'b0;
          w_data_ready_nxt = 1'b1;
          if (r_op) w_data_out_nxt = w_rdata;
        end else if (!r_mem_enable && !memory_in_use) begin
          w_mem_enable_nxt = 1'b1;
        end
      end
      S_RESPOND: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_op          <= 1'b0;
      r_byte_op     <= 1'b0;
      r_victim      <= '0;
      r_data_out    <= '0;
      r_data_ready  <= 1'b0;
      r_busy        <= 1'b0;
      r_mem_enable  <= 1'b0;
      r_mem_op      <= 1'b0;
      r_mem_address <= '0;
      r_mem_data_in <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_data_out    <= w_data_out_nxt;
      r_data_ready  <= w_data_ready_nxt;
      r_busy        <= w_busy_nxt;
      r_mem_enable  <= w_mem_enable_nxt;
      r_mem_op      <= w_mem_op_nxt;
      r_mem_address <= w_mem_address_nxt;
      r_mem_data_in <= w_mem_data_in_nxt;
      if (w_in_idle && access) begin
        r_addr    <= address;
        r_wdata   <= data_in;
        r_op      <= op;
        r_byte_op <= byte_op;
        r_victim  <= w_victim;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_update)    r_line[w_acc_set][w_acc_way] <= w_new_line;
    if (w_fill_done) r_tag[w_lat_idx][r_victim]   <= w_lat_tag;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
          r_age[s][w]   <= c_way_w'(w);
        end
      end
    end else begin
      if (w_wb_done) r_dirty[w_lat_idx][r_victim] <= 1'b0;
      if (w_update) begin
        r_valid[w_acc_set][w_acc_way] <= 1'b1;
        if (!w_src_read)      r_dirty[w_acc_set][w_acc_way] <= 1'b1;
        else if (w_fill_done) r_dirty[w_acc_set][w_acc_way] <= 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (c_way_w'(w) == w_acc_way)
            r_age[w_acc_set][w] <= c_way_w'(NUM_WAYS-1);
          else if (r_age[w_acc_set][w] > r_age[w_acc_set][w_acc_way])
            r_age[w_acc_set][w] <= r_age[w_acc_set][w] - c_way_w'(1);
        end
      end
    end
  end

  assign data_out    = r_data_out;
  assign data_ready  = r_data_ready;
  assign busy        = r_busy;
  assign mem_enable  = r_mem_enable;
  assign mem_op      = r_mem_op;
  assign mem_address = r_mem_address;
  assign mem_data_in = r_mem_data_in;

endmodule
`default_nettype wire

// File: tb/tb_set_assoc_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_set_assoc_cache
// Brief    : Directed scoreboard bench for set_assoc_cache with a line memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_set_assoc_cache;

  localparam int MEM_LAT = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         access = 1'b0;
  logic [31:0]  address = '0;
  logic [31:0]  data_in = '0;
  logic         op = 1'b0;
  logic         byte_op = 1'b0;
  logic [31:0]  data_out;
  logic         data_ready;
  logic         busy;
  logic         mem_enable;
  logic         mem_op;
  logic [31:0]  mem_address;
  logic [127:0] mem_data_in;
  logic [127:0] mem_data_out = '0;
  logic         mem_data_ready = 1'b0;
  logic         memory_in_use = 1'b0;

  set_assoc_cache dut (
    .clk           (clk),
    .reset         (reset),
    .access        (access),
    .address       (address),
    .data_in       (data_in),
    .op            (op),
    .byte_op       (byte_op),
    .data_out      (data_out),
    .data_ready    (data_ready),
    .busy          (busy),
    .mem_enable    (mem_enable),
    .mem_op        (mem_op),
    .mem_address   (mem_address),
    .mem_data_in   (mem_data_in),
    .mem_data_out  (mem_data_out),
    .mem_data_ready(mem_data_ready),
    .memory_in_use (memory_in_use)
  );

  always #5 clk = ~clk;

  int           tests = 0;
  int           fails = 0;
  logic [32:0]  sb_q[$];
  logic [32:0]  mon_e;
  logic [127:0] mem [logic [31:0]];
  int           mem_cnt = 0;
  logic [31:0]  last_rd_addr = '0;
  logic [31:0]  last_wr_addr = '0;

  int           cyc, gap, wait_cnt;
  logic         saw, c1_en, c1_op;
  logic [31:0]  c1_addr;
  logic [127:0] c1_line;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Monitor: every completion pops the oldest expectation; reads compare data.
  initial forever begin
    @(negedge clk);
    if (reset && data_ready) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ready: got data_ready=1 expected no pending request");
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e[32]) chk("rd_data", {96'h0, data_out}, {96'h0, mon_e[31:0]});
      end
    end
  end

  // Line memory: answers MEM_LAT cycles into a request, drops ready the cycle after.
  initial forever begin
    @(negedge clk);
    if (mem_data_ready) begin
      mem_data_ready = 1'b0;
      mem_cnt = 0;
    end else if (!mem_enable) begin
      mem_cnt = 0;
    end else begin
      mem_cnt++;
      if (mem_cnt == MEM_LAT) begin
        if (mem_op) begin
          mem[mem_address] = mem_data_in;
          last_wr_addr = mem_address;
        end else begin
          mem_data_out = mem.exists(mem_address) ? mem[mem_address] : '0;
          last_rd_addr = mem_address;
        end
        mem_data_ready = 1'b1;
      end
    end
  end

  task automatic do_req(input logic [31:0] a, input logic rd, input logic bop,
                        input logic [31:0] wd, input logic [31:0] exp_d,
                        output int o_cyc, output logic o_saw, output int o_gap,
                        output logic o_en, output logic o_op,
                        output logic [31:0] o_addr, output logic [127:0] o_line);
    address = a; op = rd; byte_op = bop; data_in = wd; access = 1'b1;
    sb_q.push_back({rd, exp_d});
    @(negedge clk);
    access = 1'b0;
    o_en = mem_enable; o_op = mem_op; o_addr = mem_address; o_line = mem_data_in;
    o_cyc = 1; o_saw = 1'b0; o_gap = 0;
    while (!data_ready && o_cyc < 60) begin
      if (mem_enable) o_saw = 1'b1;
      else if (o_saw) o_gap++;
      @(negedge clk);
      o_cyc++;
    end
    if (!data_ready) begin
      tests++;
      fails++;
      $display("FAIL req_timeout: got no data_ready for %0h expected completion", a);
    end
    @(negedge clk);
    chk("busy_after_done", {127'h0, busy}, 128'h0);
  endtask

  initial begin
    mem[32'h40]  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    mem[32'h80]  = {32'h80000003, 32'h80000002, 32'h80000001, 32'h80000000};
    mem[32'hC0]  = {32'hC0000003, 32'hC0000002, 32'hC0000001, 32'hC0000000};
    mem[32'h110] = {32'h01100003, 32'h01100002, 32'h01100001, 32'h01100000};
    mem[32'h120] = {32'h01200003, 32'h01200002, 32'h01200001, 32'h01200000};

    repeat (3) @(negedge clk);
    chk("rst_data_ready", {127'h0, data_ready}, 128'h0);
    chk("rst_busy", {127'h0, busy}, 128'h0);
    chk("rst_mem_enable", {127'h0, mem_enable}, 128'h0);
    chk("rst_mem_op", {127'h0, mem_op}, 128'h0);
    chk("rst_mem_address", {96'h0, mem_address}, 128'h0);
    chk("rst_data_out", {96'h0, data_out}, 128'h0);
    chk("rst_mem_data_in", mem_data_in, 128'h0);
    reset = 1'b1;
    @(negedge clk);

    // Clean miss into set 0, way 0
    do_req(32'h40, 1'b1, 1'b0, 32'h0, 32'h11111111, cyc, saw, gap, c1_en, c1_op, c1_addr, c1_line);
    chk("miss_c1_en", {127'h0, c1_en}, 128'h1);
    chk("miss_c1_op", {127'h0, c1_op}, 128'h0);
    chk("miss_c1_addr", {96'h0, c1_addr}, 128'h40);
    chk("miss_latency", cyc, 3);

    do_req(32'h44, 1'b1, 1'b0, 32'h0, 32'h22222222, cyc, saw, gap, c1_en, c1_op, c1_addr, c1_line);
    chk("hit_latency", cyc, 1);
    chk("hit_no_mem", {127'h0, saw}, 128'h0);

    do_req(32'h41, 1'b0, 1'b1, 32'hFFFFFFAB, 32'h0, cyc, saw, gap, c1_en, c1_op, c1_addr, c1_line);
    chk("bwrite_latency", cyc, 1);
    do_req(32'h40, 1'b1, 1'b0, 32'h0, 32'h1111AB11, cyc, saw, gap, c1_en, c1_op, c1_addr, c1_line);
    do_req(32'h41, 1'b1, 1'b1, 32'h0, 32'h000000AB, cyc, saw, gap, c1_en, c1_op, c1_addr, c1_line);

    do_req(32'h80, 1'b1, 1'b0, 32'h0, 32'h80000000, cyc, saw, gap, c1_en, c1_op, c1_addr, c1_line);
    chk("way1_latency", cyc, 3);
    chk("way1_c1_addr", {96'h0, c1_addr}, 128'h80);

    // Dirty victim 0x40 written back, then 0xC0 filled with no idle gap
    do_req(32'hC0, 1'b1, 1'b0, 32'h0, 32'hC0000000, cyc, saw, gap, c1_en, c1_op, c1_addr, c1_line);
    chk("wb_c1_op", {127'h0, c1_op}, 128'h1);
    chk("wb_c1_addr", {96'h0, c1_addr}, 128'h40);
    chk("wb_c1_line", c1_line, {32'h44444444, 32'h33333333, 32'h22222222, 32'h1111AB11});
    chk("wb_fill_gap", gap, 0);
    chk("wb_latency", cyc, 6);
    chk("wb_addr_seen", {96'h0, last_wr_addr}, 128'h40);
    chk("fill_addr_seen", {96'h0, last_rd_addr}, 128'hC0);

    do_req(32'h84, 1'b1, 1'b0, 32'h0, 32'h80000001, cyc, saw, gap, c1_en, c1_op, c1_addr, c1_line);
    chk("hit_0x80_latency", cyc, 1);
    do_req(32'h40, 1'b1, 1'b0, 32'h0, 32'h1111AB11, cyc, saw, gap, c1_en, c1_op, c1_addr, c1_line);
    chk("refetch_latency", cyc, 3);
    chk("refetch_c1_addr", {96'h0, c1_addr}, 128'h40);

    // Memory owned elsewhere for 5 cycles
    memory_in_use = 1'b1;
    address = 32'h118; op = 1'b1; byte_op = 1'b0; access = 1'b1;
    sb_q.push_back({1'b1, 32'h01100002});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      access = 1'b0;
      chk("inuse_hold", {127'h0, mem_enable}, 128'h0);
    end
    memory_in_use = 1'b0;
    @(negedge clk);
    chk("inuse_start_en", {127'h0, mem_enable}, 128'h1);
    chk("inuse_start_addr", {96'h0, mem_address}, 128'h110);
    chk("inuse_start_op", {127'h0, mem_op}, 128'h0);
    wait_cnt = 0;
    while (!data_ready && wait_cnt < 60) begin
      @(negedge clk);
      wait_cnt++;
    end
    chk("inuse_done", {127'h0, data_ready}, 128'h1);
    @(negedge clk);

    // Reset asserted mid-fill
    address = 32'h120; op = 1'b1; byte_op = 1'b0; access = 1'b1;
    @(negedge clk);
    access = 1'b0;
    chk("fill_active", {127'h0, mem_enable}, 128'h1);
    reset = 1'b0;
    #1;
    chk("rst_mid_en", {127'h0, mem_enable}, 128'h0);
    chk("rst_mid_busy", {127'h0, busy}, 128'h0);
    chk("rst_mid_ready", {127'h0, data_ready}, 128'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_req(32'h80, 1'b1, 1'b0, 32'h0, 32'h80000000, cyc, saw, gap, c1_en, c1_op, c1_addr, c1_line);
    chk("post_rst_miss", {127'h0, saw}, 128'h1);
    chk("post_rst_latency", cyc, 3);

    chk("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
